spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the target side of the cartridge's master SPI link.
- Lets the cartridge logic act as a peripheral to an external SPI master.
- All SPI pins are asynchronous. They are oversampled in the single `clock` domain, and bytes move to and from local logic through a one-deep transmit holding buffer and a one-deep receive buffer.

Parameters:
- WIDTH, 8, bits per SPI word.
- IDLE_WORD, 8'hFF, word shifted out when the transmit holding buffer is empty at word start.

Ports:
- clock  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high.
- sck  input  1  SPI clock from the master; asynchronous.
- cs_n  input  1  SPI chip select, active low; asynchronous.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master; 0 when not selected.
- miso_oe  output  1  output enable for the external miso tristate.
- tx_data  input  WIDTH  word to transmit.
- tx_load  input  1  write tx_data into the holding buffer; accepted only when tx_ready=1.
- tx_ready  output  1  holding buffer empty.
- rx_data  output  WIDTH  last received word.
- rx_full  output  1  rx_data holds an unread word.
- rx_ack  input  1  host consumed rx_data; clears rx_full.
- overrun  output  1  sticky: a word arrived while rx_full=1.
- clear_overrun  input  1  clears overrun.
- busy  output  1  selected and mid-word (bit count != 0).

Behaviour:
- **Reset values:** miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_full=0, overrun=0, busy=0, bit count=0. Synchronizer flops reset to sck=0, cs_n=1, mosi=0.
- **Synchronizers:** sck, cs_n and mosi each pass through 2 sync flops. A third flop on sck and on cs_n provides edge detection.
- **Timing requirement:** sck high and low phases must each be at least 4 clock periods. cs_n setup to the first sck rise must be at least 4 clocks.
- **State machine:**
  - IDLE: synced cs_n=1. Go to SELECT on the cs_n falling edge.
  - SELECT: one cycle.
    - shift register <= holding buffer if tx_ready=0 (tx_ready then goes to 1 next cycle); otherwise IDLE_WORD.
    - count <= 0; miso_oe <= 1.
    - Go to SHIFT.
  - SHIFT: miso = shift[WIDTH-1].
    - On a synced sck rise: rx_shift <= {rx_shift[WIDTH-2:0], synced mosi}; count++.
    - On a synced sck fall with count != WIDTH: shift <= shift<<1.
    - On a synced sck fall with count == WIDTH: reload from holding buffer (same rule as SELECT) and set count <= 0. This is back-to-back words with no gap.
- **Word completion:** when a sck rise makes count reach WIDTH:
  - If rx_full=0: rx_data <= assembled word, rx_full <= 1.
  - If rx_full=1 and rx_ack=0 in that cycle: the word is dropped, rx_data is unchanged, overrun <= 1.
  - rx_ack in the same cycle as completion: the new word is stored, rx_full stays 1, no overrun.
- **Latency:** rx_full rises 4 clock rising edges after the pin-level sck rise of the last bit.
- **Overrun priority:** clear_overrun and a new overrun in the same cycle leave overrun=1.
- **tx_load rules:**
  - tx_load with tx_ready=0 is ignored; the holding buffer keeps its old value.
  - tx_load is accepted in any state, including IDLE.
  - tx_ready falls on the cycle after an accepted load.
- **cs_n rise (synced) from any state:**
  - Return to IDLE; miso_oe <= 0; miso=0.
  - Partial rx bits are discarded and count <= 0, with no rx_full or overrun update.
  - The word in the shift register is discarded; the holding buffer is unaffected.
- **Framing edge cases:**
  - sck edges while cs_n=1 are ignored.
  - A cs_n rise coinciding with the final sck rise: the rise is processed first and the word completes.
- **Asynchronous reset mid-transfer:** immediately forces reset values; the transfer restarts only after a new cs_n fall.

Test Plan:
- **Single word:** tx_load 8'hA5, then cs_n low and 8 sck cycles (8-clock period) driving mosi=8'h3C → miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_full=1 four clocks after the 8th sck rise; tx_ready=1.
- **Empty transmit:** tx_ready=1 at select → miso shifts 8'hFF; received word still captured.
- **Back-to-back words:** 16 sck cycles, mosi 8'h12 then 8'h34, rx_ack after the first → rx_data 8'h12 then 8'h34, overrun=0.
- **Overrun:** same as back-to-back but no rx_ack → rx_data stays 8'h12, overrun=1. Assert clear_overrun → overrun=0.
- **Aborted word:** deassert cs_n after 5 sck rises → rx_full stays 0, busy=0, miso_oe=0. The next full word is received correctly.
- **Reset mid-transfer:** pulse reset after 3 bits → all outputs at reset values in the same cycle; a subsequent transaction works.

Source files
------------

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI responder for an external SPI master (mode 0: CPOL=0, CPHA=0, MSB
//   first). All SPI pins are asynchronous and are oversampled in the single
//   `clock` domain. Words move to and from local logic through a one-deep
//   transmit holding buffer and a one-deep receive buffer.
//
// Parameters
//   WIDTH          bits per SPI word
//   IDLE_WORD      word shifted out when nothing is waiting in the holding
//                  buffer at word start
//
// Ports
//   clock          system clock, all state on its rising edge
//   reset          asynchronous active-high reset
//   sck            SPI clock from the master (asynchronous)
//   cs_n           SPI chip select, active low (asynchronous)
//   mosi           serial data from the master
//   miso           serial data to the master, 0 when not selected
//   miso_oe        output enable for the external miso tristate
//   tx_data        word to transmit
//   tx_load        write tx_data into the holding buffer when tx_ready=1
//   tx_ready       holding buffer empty
//   rx_data        last received word
//   rx_full        rx_data holds an unread word
//   rx_ack         host consumed rx_data, clears rx_full
//   overrun        sticky flag: a word arrived while rx_full=1
//   clear_overrun  clears overrun
//   busy           selected and mid-word (bit count != 0)
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_full,
  input  logic             rx_ack,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SHIFT
  } state_t;

  state_t           state;
  logic [2:0]       sck_sync;
  logic [2:0]       cs_sync;
  logic [1:0]       mosi_sync;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic [CW-1:0]    count;
  logic             word_done;

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_bit;

  // Two flops resynchronise each pin; the third flop on sck and cs_n holds
  // the previous synced value so edges can be detected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign mosi_bit = mosi_sync[1];

  // Framing state machine together with the transmit/receive buffers.
  // word_done delays the hand-off of a completed word by one cycle so the
  // receive buffer sees the fully assembled rx_shift value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      rx_shift  <= '0;
      tx_buf    <= '0;
      count     <= '0;
      word_done <= 1'b0;
      tx_ready  <= 1'b1;
      rx_data   <= '0;
      rx_full   <= 1'b0;
      overrun   <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      word_done <= 1'b0;

      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      if (clear_overrun) begin
        overrun <= 1'b0;
      end

      // A new overrun is assigned after the clear so it takes priority.
      if (word_done) begin
        if (!rx_full) begin
          rx_data <= rx_shift;
          rx_full <= 1'b1;
        end else if (rx_ack) begin
          rx_data <= rx_shift;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          miso_oe <= 1'b0;
          count   <= '0;
          if (cs_fall) begin
            state <= SELECT;
          end
        end

        SELECT: begin
          if (!cs_rise) begin
            if (!tx_ready) begin
              shift    <= tx_buf;
              tx_ready <= 1'b1;
            end else begin
              shift <= IDLE_WORD;
            end
          end
          count   <= '0;
          miso_oe <= 1'b1;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (sck_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_bit};
            count    <= count + 1'b1;
            if (count == LAST - 1'b1) begin
              word_done <= 1'b1;
            end
          end else if (sck_fall && !cs_rise) begin
            // The falling edge after the last bit starts the next word
            // immediately, so consecutive words need no gap.
            if (count == LAST) begin
              if (!tx_ready) begin
                shift    <= tx_buf;
                tx_ready <= 1'b1;
              end else begin
                shift <= IDLE_WORD;
              end
              count <= '0;
            end else begin
              shift <= shift << 1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Deselect overrides everything above except a final-bit completion,
      // which was already flagged through word_done.
      if (cs_rise) begin
        state   <= IDLE;
        miso_oe <= 1'b0;
        count   <= '0;
      end
    end
  end

  assign miso = (state == SHIFT) && shift[WIDTH-1];
  assign busy = (state == SHIFT) && (count != '0);

endmodule
